// File: rtl/darkcore_mt_if.sv
// Strobe-handshake bundle between the fetch/hart scheduler, the data bus and darkcore_mt.
// The master drives instructions and load data; the slave (the core) returns ALU and writeback results.
interface darkcore_mt_if #(
    parameter int NHARTS = 2
);
    localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    logic          en_al;
    logic [HW-1:0] hart;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          valid_al;
    logic [31:0]   addr_al;
    logic [31:0]   data_al;
    logic [3:0]    be_al;
    logic          wr_al;
    logic          rd_al;
    logic          misal_al;
    logic [31:0]   nxpc;
    logic          en_wb;
    logic [31:0]   data_wb;
    logic          valid_wb;

    modport master (
        output en_al, hart, pc, inst, en_wb, data_wb,
        input  valid_al, addr_al, data_al, be_al, wr_al, rd_al, misal_al, nxpc, valid_wb
    );

    modport slave (
        input  en_al, hart, pc, inst, en_wb, data_wb,
        output valid_al, addr_al, data_al, be_al, wr_al, rd_al, misal_al, nxpc, valid_wb
    );
endinterface

// File: rtl/darkcore_mt.sv
// Multi-hart RV32I execute/writeback core with one register bank per hart.
// Define DARKCORE_RV32E_EN for 16 registers per bank (index bit 4 ignored).
module darkcore_mt #(
    parameter int CORE_ID = 0,
    parameter int NCORES  = 1,
    parameter int NHARTS  = 2
) (
    input  logic         clk,
    input  logic         res,
    darkcore_mt_if.slave bus
);
    localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
`ifdef DARKCORE_RV32E_EN
    localparam int RW = 4;
`else
    localparam int RW = 5;
`endif
    localparam int NREGS = 1 << RW;

    localparam logic [31:0] X3_VAL  = 32'(NCORES * NHARTS);
    localparam logic [31:0] X4_BASE = 32'(CORE_ID * NHARTS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0] rf_q [NHARTS][NREGS];
    logic [31:0] rf_d [NHARTS][NREGS];

    // Pending-writeback context captured at the ALU edge.
    logic [31:0]   res_q, res_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [HW-1:0] hart_q, hart_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    a10_q, a10_d;
    logic          ld_q, ld_d;
    logic          we_q, we_d;

    logic          valid_al_q, valid_al_d;
    logic [31:0]   addr_al_q, addr_al_d;
    logic [31:0]   data_al_q, data_al_d;
    logic [3:0]    be_al_q, be_al_d;
    logic          wr_al_q, wr_al_d;
    logic          rd_al_q, rd_al_d;
    logic          misal_al_q, misal_al_d;
    logic [31:0]   nxpc_q, nxpc_d;
    logic          valid_wb_q, valid_wb_d;

    logic          wb_fire;
    logic          wb_write;
    logic [31:0]   wb_lane;
    logic [31:0]   wb_val;

    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic          f7b5;
    logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0]   rs1_v, rs2_v, pc4;
    logic [31:0]   alu_res, nx, mem_addr, st_data;
    logic          is_ld, is_st, wr_en;
    logic [3:0]    be_calc;
    logic          misal_calc;

    function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (fn)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101: begin
                // Kept out of a ?: so the signed operand is not coerced to unsigned.
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

    function automatic logic taken(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic t;
        case (fn)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Register read with x0/x3/x4 overrides and same-edge writeback forwarding.
    function automatic logic [31:0] read_reg(input logic [HW-1:0] h, input logic [RW-1:0] r);
        logic [31:0] v;
        if (r == RW'(0))                                v = 32'b0;
        else if (r == RW'(3))                           v = X3_VAL;
        else if (r == RW'(4))                           v = X4_BASE + 32'(h);
        else if (wb_write && hart_q == h && rd_q == r)  v = wb_val;
        else if (int'(h) < NHARTS)                      v = rf_q[h][r];
        else                                            v = 32'b0;
        return v;
    endfunction

    // Writeback value: lane-extracted load data or the latched ALU result.
    always_comb begin
        wb_fire  = (state_q == ST_PEND) && bus.en_wb;
        wb_write = wb_fire && we_q && (rd_q != RW'(0)) && (rd_q != RW'(3)) && (rd_q != RW'(4));
        wb_lane  = bus.data_wb >> {a10_q, 3'b000};
        wb_val   = res_q;
        if (ld_q) begin
            case (f3_q)
                3'b000:  wb_val = {{24{wb_lane[7]}}, wb_lane[7:0]};
                3'b001:  wb_val = {{16{wb_lane[15]}}, wb_lane[15:0]};
                3'b100:  wb_val = {24'b0, wb_lane[7:0]};
                3'b101:  wb_val = {16'b0, wb_lane[15:0]};
                default: wb_val = wb_lane;
            endcase
        end else begin
            wb_val = res_q;
        end
    end

    // Instruction field and immediate decode.
    always_comb begin
        opcode  = bus.inst[6:0];
        f3      = bus.inst[14:12];
        f7b5    = bus.inst[30];
        rd_idx  = bus.inst[7 +: RW];
        rs1_idx = bus.inst[15 +: RW];
        rs2_idx = bus.inst[20 +: RW];
        imm_i   = {{20{bus.inst[31]}}, bus.inst[31:20]};
        imm_s   = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
        imm_b   = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25],
                   bus.inst[11:8], 1'b0};
        imm_u   = {bus.inst[31:12], 12'b0};
        imm_j   = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20],
                   bus.inst[30:21], 1'b0};
        rs1_v   = read_reg(bus.hart, rs1_idx);
        rs2_v   = read_reg(bus.hart, rs2_idx);
        pc4     = bus.pc + 32'd4;
    end

    // Execute: ALU result, next PC and memory request of the live instruction.
    always_comb begin
        alu_res  = 32'b0;
        wr_en    = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        nx       = pc4;
        mem_addr = rs1_v + imm_i;
        case (opcode)
            OPC_LUI: begin
                alu_res = imm_u;
                wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
                alu_res = bus.pc + imm_u;
                wr_en   = 1'b1;
            end
            OPC_JAL: begin
                alu_res = pc4;
                wr_en   = 1'b1;
                nx      = bus.pc + imm_j;
            end
            OPC_JALR: begin
                alu_res = pc4;
                wr_en   = 1'b1;
                nx      = (rs1_v + imm_i) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                if (taken(f3, rs1_v, rs2_v)) nx = bus.pc + imm_b;
                else                         nx = pc4;
            end
            OPC_LOAD: begin
                is_ld = 1'b1;
                wr_en = 1'b1;
            end
            OPC_STORE: begin
                is_st    = 1'b1;
                mem_addr = rs1_v + imm_s;
            end
            OPC_OPIMM: begin
                alu_res = alu(f3, f7b5 && (f3 == 3'b101), rs1_v, imm_i);
                wr_en   = 1'b1;
            end
            OPC_OP: begin
                alu_res = alu(f3, f7b5 && ((f3 == 3'b000) || (f3 == 3'b101)), rs1_v, rs2_v);
                wr_en   = 1'b1;
            end
            default: begin
                alu_res = 32'b0;
                wr_en   = 1'b0;
            end
        endcase
    end

    // Byte-lane enables, misalignment flag and lane-shifted store data.
    always_comb begin
        be_calc    = 4'b0000;
        misal_calc = 1'b0;
        case (f3[1:0])
            2'b00: be_calc = 4'b0001 << mem_addr[1:0];
            2'b01: begin
                be_calc    = 4'b0011 << mem_addr[1:0];
                misal_calc = mem_addr[0];
            end
            2'b10: begin
                be_calc    = 4'b1111;
                misal_calc = (mem_addr[1:0] != 2'b00);
            end
            default: begin
                be_calc    = 4'b0000;
                misal_calc = 1'b0;
            end
        endcase
        st_data = rs2_v << {mem_addr[1:0], 3'b000};
    end

    // Next state, output registers and pending context; outputs hold between strobes.
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        rd_d       = rd_q;
        hart_d     = hart_q;
        f3_d       = f3_q;
        a10_d      = a10_q;
        ld_d       = ld_q;
        we_d       = we_q;
        addr_al_d  = addr_al_q;
        data_al_d  = data_al_q;
        be_al_d    = be_al_q;
        wr_al_d    = wr_al_q;
        rd_al_d    = rd_al_q;
        misal_al_d = misal_al_q;
        nxpc_d     = nxpc_q;
        valid_al_d = bus.en_al;
        valid_wb_d = wb_fire;

        case (state_q)
            ST_IDLE: state_d = bus.en_al ? ST_PEND : ST_IDLE;
            ST_PEND: begin
                if (bus.en_al)      state_d = ST_PEND;
                else if (bus.en_wb) state_d = ST_IDLE;
                else                state_d = ST_PEND;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.en_al) begin
            res_d      = alu_res;
            rd_d       = rd_idx;
            hart_d     = bus.hart;
            f3_d       = f3;
            a10_d      = mem_addr[1:0];
            ld_d       = is_ld;
            we_d       = wr_en;
            addr_al_d  = (is_ld || is_st) ? mem_addr : 32'b0;
            data_al_d  = is_st ? st_data : 32'b0;
            be_al_d    = (is_ld || is_st) ? be_calc : 4'b0000;
            wr_al_d    = is_st;
            rd_al_d    = is_ld;
            misal_al_d = (is_ld || is_st) && misal_calc;
            nxpc_d     = nx;
        end else begin
            res_d = res_q;
        end
    end

    // Register-file next value: a single write port from the writeback phase.
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_d[h][r] = (wb_write && int'(hart_q) == h && int'(rd_q) == r) ? wb_val : rf_q[h][r];
            end
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int h = 0; h < NHARTS; h++) begin
                for (int r = 0; r < NREGS; r++) begin
                    rf_q[h][r] <= 32'b0;
                end
            end
            state_q    <= ST_IDLE;
            res_q      <= 32'b0;
            rd_q       <= '0;
            hart_q     <= '0;
            f3_q       <= 3'b000;
            a10_q      <= 2'b00;
            ld_q       <= 1'b0;
            we_q       <= 1'b0;
            valid_al_q <= 1'b0;
            addr_al_q  <= 32'b0;
            data_al_q  <= 32'b0;
            be_al_q    <= 4'b0000;
            wr_al_q    <= 1'b0;
            rd_al_q    <= 1'b0;
            misal_al_q <= 1'b0;
            nxpc_q     <= 32'b0;
            valid_wb_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            state_q    <= state_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            hart_q     <= hart_d;
            f3_q       <= f3_d;
            a10_q      <= a10_d;
            ld_q       <= ld_d;
            we_q       <= we_d;
            valid_al_q <= valid_al_d;
            addr_al_q  <= addr_al_d;
            data_al_q  <= data_al_d;
            be_al_q    <= be_al_d;
            wr_al_q    <= wr_al_d;
            rd_al_q    <= rd_al_d;
            misal_al_q <= misal_al_d;
            nxpc_q     <= nxpc_d;
            valid_wb_q <= valid_wb_d;
        end
    end

    assign bus.valid_al = valid_al_q;
    assign bus.addr_al  = addr_al_q;
    assign bus.data_al  = data_al_q;
    assign bus.be_al    = be_al_q;
    assign bus.wr_al    = wr_al_q;
    assign bus.rd_al    = rd_al_q;
    assign bus.misal_al = misal_al_q;
    assign bus.nxpc     = nxpc_q;
    assign bus.valid_wb = valid_wb_q;
endmodule
